// File: rtl/fwrisc_fpga_tb_mon_pkg.sv
// fwrisc_fpga_tb_mon_pkg: receive-state encoding and FIFO count sizing for the FPGA bench monitor.
package fwrisc_fpga_tb_mon_pkg;
   typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} rx_state_e;
   function automatic int count_width(input int depth);
      return $clog2(depth) + 1;
   endfunction
endpackage

// File: rtl/fwrisc_fpga_tb_fifo.sv
// fwrisc_fpga_tb_fifo: first-word fall-through FIFO; a push while full is taken only alongside a pop.
module fwrisc_fpga_tb_fifo
   import fwrisc_fpga_tb_mon_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          push,
   input  logic [WIDTH-1:0]              din,
   input  logic                          pop,
   output logic [WIDTH-1:0]              dout,
   output logic                          full,
   output logic                          empty,
   output logic [count_width(DEPTH)-1:0] count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = count_width(DEPTH);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0] rd, wr;
   logic pop_ok, push_ok;
   assign empty   = count == '0;
   assign full    = count == CW'(DEPTH);
   assign pop_ok  = pop && !empty;
   assign push_ok = push && (!full || pop_ok);
   assign dout    = empty ? '0 : mem[rd];
   always_ff @(posedge clock)
      if (push_ok) mem[wr] <= din;
   always_ff @(posedge clock) begin
      if (reset) begin
         rd    <= '0;
         wr    <= '0;
         count <= '0;
      end else begin
         if (push_ok) wr <= wr + 1'b1;
         if (pop_ok) rd <= rd + 1'b1;
         count <= count + CW'(push_ok) - CW'(pop_ok);
      end
   end
endmodule

// File: rtl/fwrisc_fpga_tb_mon.sv
// fwrisc_fpga_tb_mon: decodes the DUT UART line into a byte FIFO and counts LED transitions.
module fwrisc_fpga_tb_mon
   import fwrisc_fpga_tb_mon_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16,
   parameter int DATA_BITS    = 8,
   parameter int FIFO_DEPTH   = 8,
   parameter int NUM_LEDS     = 2,
   parameter int CNT_W        = 16
) (
   input  logic                               clock,
   input  logic                               reset,
   input  logic                               rx,
   input  logic [NUM_LEDS-1:0]                leds,
   output logic                               byte_valid,
   output logic [DATA_BITS-1:0]               byte_data,
   input  logic                               byte_ready,
   output logic [count_width(FIFO_DEPTH)-1:0] fifo_count,
   output logic                               framing_err,
   output logic                               overflow,
   output logic [NUM_LEDS*CNT_W-1:0]          led_toggles
);
   localparam int TW = $clog2(CLKS_PER_BIT);
   localparam int IW = $clog2(DATA_BITS);
   rx_state_e state, state_n;
   logic [1:0] rx_q;
   logic rx_s, rx_p;
   logic [NUM_LEDS-1:0] led_q, led_s, led_p;
   logic [TW-1:0] timer;
   logic [IW-1:0] idx;
   logic [DATA_BITS-1:0] sh;
   logic [CNT_W-1:0] cnt [NUM_LEDS];
   logic tick_half, tick_full, push, stop_bad, full, empty;
   assign rx_s      = rx_q[1];
   assign tick_half = timer == TW'(CLKS_PER_BIT/2 - 1);
   assign tick_full = timer == TW'(CLKS_PER_BIT - 1);
   assign byte_valid = !empty;
   always_ff @(posedge clock) begin
      if (reset) begin
         rx_q  <= 2'b11;
         rx_p  <= 1'b1;
         led_q <= '0;
         led_s <= '0;
         led_p <= '0;
      end else begin
         rx_q  <= {rx_q[0], rx};
         rx_p  <= rx_s;
         led_q <= leds;
         led_s <= led_q;
         led_p <= led_s;
      end
   end
   always_ff @(posedge clock)
      state <= reset ? IDLE : state_n;
   always_comb begin
      state_n = state;
      case (state)
         IDLE:      state_n = (rx_p && !rx_s) ? START : IDLE;
         START:     state_n = tick_half ? (rx_s ? IDLE : DATA) : START;
         DATA:      state_n = (tick_full && idx == IW'(DATA_BITS - 1)) ? STOP : DATA;
         STOP:      state_n = tick_full ? (rx_s ? IDLE : WAIT_IDLE) : STOP;
         WAIT_IDLE: state_n = rx_s ? IDLE : WAIT_IDLE;
         default:   state_n = IDLE;
      endcase
   end
   always_comb begin
      push     = state == STOP && tick_full && rx_s;
      stop_bad = state == STOP && tick_full && !rx_s;
   end
   // the timer restarts on every state change and at each full bit period
   always_ff @(posedge clock) begin
      if (reset) begin
         timer <= '0;
         idx   <= '0;
         sh    <= '0;
      end else begin
         timer <= (state != state_n || tick_full) ? '0 : timer + 1'b1;
         if (state == START) idx <= '0;
         if (state == DATA && tick_full) begin
            idx <= idx + 1'b1;
            sh  <= {rx_s, sh[DATA_BITS-1:1]};
         end
      end
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         framing_err <= 1'b0;
         overflow    <= 1'b0;
      end else begin
         framing_err <= framing_err | stop_bad;
         overflow    <= overflow | (push && full && !byte_ready);
      end
   end
   always_ff @(posedge clock) begin
      for (int i = 0; i < NUM_LEDS; i++)
         if (reset) cnt[i] <= '0;
         else if (led_s[i] != led_p[i] && cnt[i] != '1) cnt[i] <= cnt[i] + 1'b1;
   end
   for (genvar g = 0; g < NUM_LEDS; g++) begin : g_led
      assign led_toggles[g*CNT_W +: CNT_W] = cnt[g];
   end
   fwrisc_fpga_tb_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (push),
      .din   (sh),
      .pop   (byte_valid && byte_ready),
      .dout  (byte_data),
      .full  (full),
      .empty (empty),
      .count (fifo_count)
   );
endmodule

// File: doc/fwrisc_fpga_tb_mon.md
Name: fwrisc_fpga_tb_mon

Overview:
Parametrised testbench-side monitor for the FPGA top-level. It decodes the DUT UART transmit line into bytes and buffers them in a FIFO for the bench to pop. It also counts transitions on a configurable number of LED outputs. It sits inside the FPGA bench HDL alongside the DUT instance, and gives the bench cycle-accurate, checkable output instead of raw pins.

Parameters:
- CLKS_PER_BIT, 16: clock cycles per UART bit. Minimum 4.
- DATA_BITS, 8: UART data bits per frame. Range 5..8. No parity, one stop bit.
- FIFO_DEPTH, 8: received-byte FIFO entries. Must be a power of 2, at least 2.
- NUM_LEDS, 2: number of LED inputs monitored.
- CNT_W, 16: width of each LED toggle counter.

Ports:
- clock, input, 1: single clock.
- reset, input, 1: synchronous, active-high reset.
- rx, input, 1: DUT UART tx line. Asynchronous; idles high.
- leds, input, NUM_LEDS: DUT LED outputs. Asynchronous.
- byte_valid, output, 1: FIFO non-empty.
- byte_data, output, DATA_BITS: FIFO head byte (first-word fall-through).
- byte_ready, input, 1: pop the head byte when byte_valid is also high.
- fifo_count, output, $clog2(FIFO_DEPTH)+1: current occupancy.
- framing_err, output, 1: sticky; set when a stop bit is sampled low.
- overflow, output, 1: sticky; set when a byte is dropped because the FIFO is full.
- led_toggles, output, NUM_LEDS*CNT_W: per-LED edge counters; LED i occupies bits [i*CNT_W +: CNT_W].

Behaviour:
- Reset values:
  - byte_valid=0, byte_data=0, fifo_count=0, framing_err=0, overflow=0, led_toggles=0.
  - rx synchroniser flops=1; led synchroniser flops=0; receive FSM in IDLE.
- Synchronisers: rx and each led pass through 2 flops before any use. All latencies below are measured from the synchronised signal (rx_s, led_s).
- Receive FSM states: IDLE, START, DATA, STOP, WAIT_IDLE. It uses a bit-timer (0..CLKS_PER_BIT-1) and a bit index (0..DATA_BITS-1).
  - IDLE: rx_s falling (prev 1, now 0) -> START, timer=0.
  - START: at timer==CLKS_PER_BIT/2-1, sample rx_s.
    - 0 -> DATA, timer=0, index=0.
    - 1 -> IDLE (glitch rejected, no flag).
  - DATA: at timer==CLKS_PER_BIT-1, shift rx_s in LSB-first and reset the timer. After bit DATA_BITS-1 -> STOP.
  - STOP: at timer==CLKS_PER_BIT-1, sample rx_s.
    - 1 -> push byte, go to IDLE.
    - 0 -> framing_err=1, byte discarded, go to WAIT_IDLE.
  - WAIT_IDLE: stay until rx_s==1, then go to IDLE. A line held low never re-triggers a frame.
- FIFO:
  - Push occurs in the stop-sample cycle. byte_valid rises the next cycle if the FIFO was empty.
  - Pop occurs when byte_valid && byte_ready. The next entry appears the following cycle.
  - Push while full with no simultaneous pop: byte dropped, overflow=1, contents unchanged.
  - Push while full with a simultaneous pop: both are accepted; count stays at FIFO_DEPTH.
  - Push and pop on an empty FIFO: the push is accepted; the pop is ignored because byte_valid=0.
  - Pointers wrap modulo FIFO_DEPTH. fifo_count is exact at all times.
- LED counters:
  - Count increments by 1 on any change of led_s[i] versus the previous cycle.
  - Counters saturate at 2^CNT_W-1; no wrap.
- Sticky flags (framing_err, overflow) clear only on reset.
- Reset mid-frame: the FSM returns to IDLE, the FIFO empties and the partial byte is discarded. A frame already in progress on rx after reset deasserts is not decoded unless a fresh falling edge is seen.

Decomposition:
- Package fwrisc_fpga_tb_mon_pkg: the receive-state enum (IDLE, START, DATA, STOP, WAIT_IDLE) and a function computing the count width from FIFO_DEPTH.
- Sub-module fwrisc_fpga_tb_fifo: synchronous FIFO with parameters WIDTH and DEPTH, first-word fall-through, full/empty/count outputs, and simultaneous push/pop-when-full semantics as specified above.
- The UART FSM and LED counters stay in the top module.

Test Plan:
- Single byte: CLKS_PER_BIT=16; drive 0xA5 LSB-first with correct framing and byte_ready=0.
  -> byte_valid=1, byte_data=0xA5, fifo_count=1, framing_err=0.
- Glitch rejection: rx low for 4 cycles, then high.
  -> no byte, no flag, FSM back in IDLE.
- Framing error: send 0x3C with stop bit 0, hold rx low for 40 cycles, then send 0x11 correctly.
  -> framing_err=1, only 0x11 in the FIFO.
- Overflow: FIFO_DEPTH=8; send 9 bytes 0x00..0x08 with byte_ready=0.
  -> fifo_count=8, overflow=1, pops return 0x00..0x07 in order.
- Full with pop: FIFO full; hold byte_ready=1 in the stop-sample cycle of a 9th byte.
  -> no overflow, count stays 8, 9th byte is last out.
- LED counting: toggle leds[1] 5 times and leds[0] 0 times; separately, with CNT_W=3, toggle leds[0] 10 times.
  -> first case: led_toggles[1]=5, led_toggles[0]=0; CNT_W=3 case: counter saturates at 7.
- Reset mid-frame: assert reset during DATA of 0x5A.
  -> all outputs at reset values, and the next clean frame decodes correctly.
